// File: rtl/alu_txn_engine_pkg.sv
// Shared types for the ALU transaction engine: op encodings, FSM states and
// the op/response payloads carried between the request and response sides.
package alu_txn_engine_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned RES_W  = 12;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0]        sel;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              cin;
  } op_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             cout;
    logic [1:0]       sel;
  } rsp_t;

endpackage

// File: rtl/alu_txn_engine_settle.sv
// Settle-window down-counter: load starts the window, zero rises one cycle
// after the count reaches 0 so capture lands SETTLE_CYCLES+1 edges after load.
module alu_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b0;
    end else if (load) begin
      count <= CW'(SETTLE_CYCLES - 1);
      zero  <= 1'b0;
    end else begin
      zero <= (count == '0);
      if (count != '0) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_txn_engine.sv
// ALU transaction front-end: latches one op per request handshake, holds the
// ALU inputs for a settle window, then returns the captured result.
module alu_txn_engine
  import alu_txn_engine_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TAG_W         = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_sel,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic             req_cin,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       alu_a4,
  output logic [3:0]       alu_b4,
  output logic [5:0]       alu_a6,
  output logic [5:0]       alu_b6,
  output logic [7:0]       alu_a8,
  output logic [7:0]       alu_b8,
  output logic [1:0]       alu_sel,
  output logic             alu_carry_in,
  input  logic [11:0]      alu_result,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [11:0]      rsp_result,
  output logic             rsp_cout,
  output logic [1:0]       rsp_sel,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e           state, state_next;
  logic             timer_zero;
  logic             req_fire, rsp_fire, capture;
  op_t              op;
  logic [TAG_W-1:0] op_tag;
  rsp_t             rsp;

  alu_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (req_fire),
    .zero (timer_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_fire) state_next = S_SETTLE;
      S_SETTLE: if (timer_zero) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = req_valid ? S_SETTLE : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Accept can overlap the response handshake, giving back-to-back ops.
  always_comb begin
    req_ready = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
    req_fire  = req_valid && req_ready;
    rsp_fire  = (state == S_RESP) && rsp_ready;
    capture   = (state == S_SETTLE) && timer_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op        <= '0;
      op_tag    <= '0;
      rsp       <= '0;
      rsp_tag   <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      if (req_fire) begin
        op     <= '{sel: req_sel, a: req_a, b: req_b, cin: req_cin};
        op_tag <= req_tag;
      end
      if (capture) begin
        rsp     <= '{result: alu_result, cout: alu_carry_out, sel: op.sel};
        rsp_tag <= op_tag;
      end
      rsp_valid <= (state_next == S_RESP);
      busy      <= (state_next != S_IDLE);
      if (rsp_fire && (op_count != '1)) op_count <= op_count + CNT_W'(1);
    end
  end

  assign alu_a8       = op.a;
  assign alu_b8       = op.b;
  assign alu_a6       = op.a[5:0];
  assign alu_b6       = op.b[5:0];
  assign alu_a4       = op.a[3:0];
  assign alu_b4       = op.b[3:0];
  assign alu_sel      = op.sel;
  assign alu_carry_in = op.cin;
  assign rsp_result   = rsp.result;
  assign rsp_cout     = rsp.cout;
  assign rsp_sel      = rsp.sel;

endmodule

// File: tb/tb_alu_txn_engine.sv
// Bench for alu_txn_engine: behavioural ALU behind the engine, directed and
// randomized ops checked against an integer-arithmetic reference model.
module tb_alu_txn_engine;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned CNT_W  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [1:0]       req_sel;
  logic [7:0]       req_a, req_b;
  logic             req_cin;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       alu_a4, alu_b4;
  logic [5:0]       alu_a6, alu_b6;
  logic [7:0]       alu_a8, alu_b8;
  logic [1:0]       alu_sel;
  logic             alu_carry_in;
  logic [11:0]      alu_result;
  logic             alu_carry_out;
  logic             rsp_valid, rsp_ready;
  logic [11:0]      rsp_result;
  logic             rsp_cout;
  logic [1:0]       rsp_sel;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  logic [1:0]       cur_sel;
  logic [7:0]       cur_a, cur_b;
  logic             cur_cin;
  logic [TAG_W-1:0] cur_tag;
  logic [11:0]      exp_res;
  logic             exp_cout;

  alu_txn_engine #(.SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_tag(req_tag),
    .alu_a4(alu_a4), .alu_b4(alu_b4), .alu_a6(alu_a6), .alu_b6(alu_b6),
    .alu_a8(alu_a8), .alu_b8(alu_b8), .alu_sel(alu_sel), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_sel(rsp_sel), .rsp_tag(rsp_tag),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting behind the engine.
  always_comb begin
    alu_result    = '0;
    alu_carry_out = 1'b0;
    case (alu_sel)
      2'b00: {alu_carry_out, alu_result[3:0]} = {1'b0, alu_a4} + {1'b0, alu_b4} + 5'(alu_carry_in);
      2'b01: {alu_carry_out, alu_result[7:0]} = {1'b0, alu_a8} - {1'b0, alu_b8} - 9'(alu_carry_in);
      2'b10: alu_result = 12'(alu_a6) * 12'(alu_b6);
      default: alu_result[3:0] = alu_a4 & alu_b4;
    endcase
  end

  // Reference: expected {cout, result} from the request fields, in plain integers.
  function automatic logic [12:0] model(input logic [1:0] sel, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int r;
    int c;
    case (sel)
      2'd0: begin
        r = int'(a) % 16 + int'(b) % 16 + int'(cin);
        c = r / 16;
        r = r % 16;
      end
      2'd1: begin
        r = int'(a) - int'(b) - int'(cin);
        c = (r < 0) ? 1 : 0;
        if (r < 0) r = r + 256;
      end
      2'd2: begin
        r = (int'(a) % 64) * (int'(b) % 64);
        c = 0;
      end
      default: begin
        r = int'(a) % 16;
        r = r & (int'(b) % 16);
        c = 0;
      end
    endcase
    return {1'(c), 12'(r)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_sel = sel; req_a = a; req_b = b; req_cin = cin; req_tag = tag;
    cur_sel = sel; cur_a = a; cur_b = b; cur_cin = cin; cur_tag = tag;
    {exp_cout, exp_res} = model(sel, a, b, cin);
  endtask

  task automatic check_rsp();
    check("rsp_result", 64'(rsp_result), 64'(exp_res));
    check("rsp_cout", 64'(rsp_cout), 64'(exp_cout));
    check("rsp_sel", 64'(rsp_sel), 64'(cur_sel));
    check("rsp_tag", 64'(rsp_tag), 64'(cur_tag));
  endtask

  // Called just after the accept edge; counts negedges until rsp_valid.
  task automatic wait_rsp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      check("alu_ports",
            64'({alu_a8, alu_b8, alu_a6, alu_b6, alu_a4, alu_b4, alu_sel, alu_carry_in}),
            64'({cur_a, cur_b, cur_a[5:0], cur_b[5:0], cur_a[3:0], cur_b[3:0], cur_sel, cur_cin}));
      check("op_count_hold", 64'(op_count), 64'(model_cnt));
      if (!rsp_valid) check("busy_settle", 64'(busy), 64'(1));
    end while (!rsp_valid && n < 20);
    check("latency", 64'(n), 64'(SETTLE + 2));
    check_rsp();
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [TAG_W-1:0] tag);
    int n = 0;
    @(negedge clk);
    drive_req(sel, a, b, cin, tag);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
  endtask

  task automatic hold_rsp(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_valid_hold", 64'(rsp_valid), 64'(1));
      check("req_ready_stall", 64'(req_ready), 64'(0));
      check_rsp();
    end
  endtask

  task automatic complete(input int hold);
    hold_rsp(hold);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (model_cnt < 3) model_cnt++;
    @(negedge clk);
    check("op_count", 64'(op_count), 64'(model_cnt));
    check("rsp_valid_drop", 64'(rsp_valid), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic complete_b2b(input int hold, input logic [1:0] sel, input logic [7:0] a,
                              input logic [7:0] b, input logic cin, input logic [TAG_W-1:0] tag);
    hold_rsp(hold);
    rsp_ready = 1'b1;
    drive_req(sel, a, b, cin, tag);
    #1 check("req_ready_b2b", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1 begin
      rsp_ready = 1'b0;
      req_valid = 1'b0;
    end
    if (model_cnt < 3) model_cnt++;
    wait_rsp();
  endtask

  task automatic send_rand();
    send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom), TAG_W'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_sel = '0; req_a = '0; req_b = '0; req_cin = 1'b0; req_tag = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({rsp_valid, busy, op_count, rsp_result, rsp_cout, rsp_sel, rsp_tag}), 64'(0));
    check("reset_alu", 64'({alu_a8, alu_b8, alu_sel, alu_carry_in}), 64'(0));
    rst = 1'b0;
    #1 check("req_ready_after_reset", 64'(req_ready), 64'(1));

    send(2'b00, 8'd5, 8'd3, 1'b0, 4'd1);
    check("add_result", 64'(rsp_result[3:0]), 64'(8));
    complete(0);
    send(2'b01, 8'd100, 8'd25, 1'b0, 4'd2);
    check("sub_result", 64'(rsp_result[7:0]), 64'(75));
    complete(1);
    send(2'b10, 8'd15, 8'd3, 1'b0, 4'd3);
    check("mul_result", 64'(rsp_result), 64'(12'h02D));
    complete(0);
    send(2'b11, 8'b0000_1101, 8'b0000_1010, 1'b0, 4'd4);
    check("and_result", 64'(rsp_result[3:0]), 64'(4'b1000));
    complete_b2b(5, 2'b00, 8'd9, 8'd7, 1'b1, 4'd5);
    check("add_carry", 64'({rsp_cout, rsp_result}), 64'({1'b1, 12'h001}));
    complete(0);

    // Reset while an op is settling.
    @(negedge clk);
    drive_req(2'b01, 8'd50, 8'd60, 1'b1, 4'd6);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 begin
      check("midreset_outputs",
            64'({rsp_valid, busy, op_count, rsp_result, rsp_cout, rsp_sel, rsp_tag}), 64'(0));
      check("midreset_alu", 64'({alu_a8, alu_b8, alu_sel, alu_carry_in}), 64'(0));
      check("midreset_req_ready", 64'(req_ready), 64'(1));
    end
    model_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_rsp_after_reset", 64'({rsp_valid, op_count}), 64'(0));
    end

    // Five ops exercise counter saturation: 1, 2, 3, 3, 3.
    for (int i = 0; i < 5; i++) begin
      send_rand();
      complete(i % 2);
    end

    send_rand();
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        complete_b2b(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
                     8'($urandom), 1'($urandom), TAG_W'($urandom));
      end else begin
        complete(int'($urandom_range(0, 3)));
        send_rand();
      end
    end
    complete(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
